// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch (I) and data (D) share one memory port.
// One transaction in flight; D has priority, with a starvation counter guaranteeing I progress.
package mem_arbiter_pkg;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
    typedef enum logic {OWN_I, OWN_D} owner_e;
endpackage

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    // Instruction fetch side
    input  logic  i_req_i,
    input  addr_t i_addr_i,
    output logic  i_gnt_o,
    output logic  i_rvalid_o,
    output data_t i_rdata_o,
    // Data side
    input  logic  d_req_i,
    input  logic  d_we_i,
    input  addr_t d_addr_i,
    input  data_t d_wdata_i,
    output logic  d_gnt_o,
    output logic  d_rvalid_o,
    output data_t d_rdata_o,
    // Shared memory port
    output logic  m_req_o,
    output logic  m_we_o,
    output addr_t m_addr_o,
    output data_t m_wdata_o,
    input  logic  m_gnt_i,
    input  logic  m_rvalid_i,
    input  data_t m_rdata_i
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_e     state;
    owner_e     owner;
    logic       lat_we;
    addr_t      lat_addr;
    data_t      lat_wdata;
    logic [3:0] starve_cnt;

    logic is_idle;
    logic pick_i;
    logic resp_fire;

    // I overrides D only once D has won STARVE_MAX times in a row while I waited.
    assign is_idle   = (state == IDLE);
    assign pick_i    = i_req_i & (~d_req_i | (starve_cnt == STARVE_LIM));
    assign i_gnt_o   = is_idle & pick_i;
    assign d_gnt_o   = is_idle & d_req_i & ~pick_i;

    // A response counts in REQ only when it arrives together with the accept.
    assign resp_fire  = m_rvalid_i & (((state == REQ) & m_gnt_i) | (state == RESP));
    assign i_rvalid_o = resp_fire & (owner == OWN_I);
    assign d_rvalid_o = resp_fire & (owner == OWN_D);
    assign i_rdata_o  = m_rdata_i;
    assign d_rdata_o  = m_rdata_i;

    assign m_req_o   = (state == REQ);
    assign m_we_o    = (state == REQ) & lat_we;
    assign m_addr_o  = lat_addr;
    assign m_wdata_o = lat_wdata;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_I;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_gnt_o) begin
                        owner      <= OWN_I;
                        lat_we     <= 1'b0;
                        lat_addr   <= i_addr_i;
                        lat_wdata  <= '0;
                        starve_cnt <= '0;
                        state      <= REQ;
                    end else if (d_gnt_o) begin
                        owner     <= OWN_D;
                        lat_we    <= d_we_i;
                        lat_addr  <= d_addr_i;
                        lat_wdata <= d_wdata_i;
                        if (i_req_i && (starve_cnt != STARVE_LIM))
                            starve_cnt <= starve_cnt + 4'd1;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (m_gnt_i)
                        state <= m_rvalid_i ? IDLE : RESP;
                end
                RESP: begin
                    if (m_rvalid_i)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter: fetch read, D priority, starvation order,
// zero-latency memory, backpressure and reset during a response.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req_i;
    logic [31:0] i_addr_i;
    logic        i_gnt_o;
    logic        i_rvalid_o;
    logic [31:0] i_rdata_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic        d_gnt_o;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        m_req_o;
    logic        m_we_o;
    logic [31:0] m_addr_o;
    logic [31:0] m_wdata_o;
    logic        m_gnt_i;
    logic        m_rvalid_i;
    logic [31:0] m_rdata_i;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req_i    (i_req_i),
        .i_addr_i   (i_addr_i),
        .i_gnt_o    (i_gnt_o),
        .i_rvalid_o (i_rvalid_o),
        .i_rdata_o  (i_rdata_o),
        .d_req_i    (d_req_i),
        .d_we_i     (d_we_i),
        .d_addr_i   (d_addr_i),
        .d_wdata_i  (d_wdata_i),
        .d_gnt_o    (d_gnt_o),
        .d_rvalid_o (d_rvalid_o),
        .d_rdata_o  (d_rdata_o),
        .m_req_o    (m_req_o),
        .m_we_o     (m_we_o),
        .m_addr_o   (m_addr_o),
        .m_wdata_o  (m_wdata_o),
        .m_gnt_i    (m_gnt_i),
        .m_rvalid_i (m_rvalid_i),
        .m_rdata_i  (m_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Both requesters asking, memory answers in the REQ cycle: expect D x4 then I, repeated.
    task automatic starve_run(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            settle();
            check({tag, "_order"}, 32'({i_gnt_o, d_gnt_o}), ((k % 5) == 4) ? 32'd2 : 32'd1);
            check({tag, "_idle_rv"}, 32'({i_rvalid_o, d_rvalid_o}), 32'd0);
            advance();
            settle();
            check({tag, "_mreq"}, 32'(m_req_o), 32'd1);
            check({tag, "_rv"}, 32'({i_rvalid_o, d_rvalid_o}), ((k % 5) == 4) ? 32'd2 : 32'd1);
            check({tag, "_gnt_busy"}, 32'({i_gnt_o, d_gnt_o}), 32'd0);
            advance();
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        i_req_i    = 1'b0;
        i_addr_i   = '0;
        d_req_i    = 1'b0;
        d_we_i     = 1'b0;
        d_addr_i   = '0;
        d_wdata_i  = '0;
        m_gnt_i    = 1'b0;
        m_rvalid_i = 1'b0;
        m_rdata_i  = '0;

        settle();
        check("rst_mreq", 32'(m_req_o), 32'd0);
        check("rst_maddr", m_addr_o, 32'd0);
        check("rst_gnt", 32'({i_gnt_o, d_gnt_o}), 32'd0);
        advance();
        rst_n = 1'b1;

        // Fetch-only read with a slow memory.
        i_req_i  = 1'b1;
        i_addr_i = 32'h0000_0100;
        settle();
        check("t1_igrant", 32'(i_gnt_o), 32'd1);
        check("t1_dgrant", 32'(d_gnt_o), 32'd0);
        check("t1_mreq_c0", 32'(m_req_o), 32'd0);
        advance();
        i_req_i  = 1'b0;
        i_addr_i = 32'hFFFF_FFFF;
        settle();
        check("t1_mreq_c1", 32'(m_req_o), 32'd1);
        check("t1_maddr_c1", m_addr_o, 32'h0000_0100);
        check("t1_mwe", 32'(m_we_o), 32'd0);
        advance();
        m_gnt_i = 1'b1;
        settle();
        check("t1_mreq_c2", 32'(m_req_o), 32'd1);
        check("t1_maddr_c2", m_addr_o, 32'h0000_0100);
        check("t1_rv_c2", 32'(i_rvalid_o), 32'd0);
        advance();
        m_gnt_i = 1'b0;
        settle();
        check("t1_mreq_c3", 32'(m_req_o), 32'd0);
        check("t1_rv_c3", 32'(i_rvalid_o), 32'd0);
        advance();
        m_rvalid_i = 1'b1;
        m_rdata_i  = 32'h0050_0093;
        settle();
        check("t1_irv_c4", 32'(i_rvalid_o), 32'd1);
        check("t1_irdata_c4", i_rdata_o, 32'h0050_0093);
        check("t1_drv_c4", 32'(d_rvalid_o), 32'd0);
        advance();
        // Back in IDLE: a stray response must not surface.
        m_rdata_i = 32'h1111_2222;
        settle();
        check("t1_idle_rv", 32'({i_rvalid_o, d_rvalid_o}), 32'd0);
        check("t1_idle_mreq", 32'(m_req_o), 32'd0);
        advance();
        m_rvalid_i = 1'b0;

        // Simultaneous requests: D store wins, I follows after the mandatory IDLE.
        i_req_i   = 1'b1;
        i_addr_i  = 32'h0000_0300;
        d_req_i   = 1'b1;
        d_we_i    = 1'b1;
        d_addr_i  = 32'h0000_2000;
        d_wdata_i = 32'hDEAD_BEEF;
        settle();
        check("t2_gnt", 32'({i_gnt_o, d_gnt_o}), 32'd1);
        advance();
        d_req_i    = 1'b0;
        d_we_i     = 1'b0;
        d_wdata_i  = 32'h0;
        m_gnt_i    = 1'b1;
        m_rvalid_i = 1'b1;
        settle();
        check("t2_mwe", 32'(m_we_o), 32'd1);
        check("t2_maddr", m_addr_o, 32'h0000_2000);
        check("t2_mwdata", m_wdata_o, 32'hDEAD_BEEF);
        check("t2_rv", 32'({i_rvalid_o, d_rvalid_o}), 32'd1);
        check("t2_gnt_busy", 32'({i_gnt_o, d_gnt_o}), 32'd0);
        advance();
        m_gnt_i    = 1'b0;
        m_rvalid_i = 1'b0;
        settle();
        check("t2_igrant", 32'({i_gnt_o, d_gnt_o}), 32'd2);
        advance();
        i_req_i    = 1'b0;
        m_gnt_i    = 1'b1;
        m_rvalid_i = 1'b1;
        settle();
        check("t2_imaddr", m_addr_o, 32'h0000_0300);
        check("t2_imwe", 32'(m_we_o), 32'd0);
        check("t2_irv", 32'({i_rvalid_o, d_rvalid_o}), 32'd2);
        advance();

        // Starvation with a zero-latency memory: D,D,D,D,I,D,D,D,D,I.
        i_req_i  = 1'b1;
        d_req_i  = 1'b1;
        d_addr_i = 32'h0000_0040;
        starve_run("t3", 10);

        // Backpressure: address held while d_addr_i moves.
        m_gnt_i    = 1'b0;
        m_rvalid_i = 1'b0;
        d_addr_i   = 32'h0000_4000;
        settle();
        check("t4_dgrant", 32'({i_gnt_o, d_gnt_o}), 32'd1);
        advance();
        d_req_i = 1'b0;
        for (int j = 0; j < 5; j++) begin
            d_addr_i = 32'h0000_5000 + 32'(j);
            settle();
            check("t4_mreq_hold", 32'(m_req_o), 32'd1);
            check("t4_maddr_hold", m_addr_o, 32'h0000_4000);
            check("t4_gnt_busy", 32'({i_gnt_o, d_gnt_o}), 32'd0);
            advance();
        end
        m_gnt_i = 1'b1;
        advance();
        m_gnt_i = 1'b0;
        settle();
        check("t4_resp_mreq", 32'(m_req_o), 32'd0);
        advance();

        // Reset while in RESP, then a late response after release.
        rst_n   = 1'b0;
        i_req_i = 1'b0;
        settle();
        check("t5_rst_mreq", 32'(m_req_o), 32'd0);
        check("t5_rst_maddr", m_addr_o, 32'd0);
        check("t5_rst_mwdata", m_wdata_o, 32'd0);
        check("t5_rst_mwe", 32'(m_we_o), 32'd0);
        advance();
        rst_n      = 1'b1;
        m_rvalid_i = 1'b1;
        m_rdata_i  = 32'hCAFE_F00D;
        settle();
        check("t5_late_rv", 32'({i_rvalid_o, d_rvalid_o}), 32'd0);
        check("t5_late_mreq", 32'(m_req_o), 32'd0);
        advance();

        // The starve counter was 1 before reset; a cleared counter gives D x4 then I.
        i_req_i = 1'b1;
        d_req_i = 1'b1;
        m_gnt_i = 1'b1;
        starve_run("t5", 5);

        i_req_i    = 1'b0;
        d_req_i    = 1'b0;
        m_gnt_i    = 1'b0;
        m_rvalid_i = 1'b0;
        advance();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, SHALL be the max consecutive D grants while I waits (range 1..15).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 i_req_i  input  1  SHALL be the fetch request, held until granted.
REQ-005 i_addr_i  input  32 (addr_t)  SHALL be the fetch address.
REQ-006 i_gnt_o  output  1  SHALL be the fetch grant pulse.
REQ-007 i_rvalid_o  output  1  SHALL be the fetch response valid.
REQ-008 i_rdata_o  output  32 (data_t)  SHALL be the fetch response data.
REQ-009 d_req_i, d_we_i  input  1 each  SHALL be the data request and write-enable (1=store).
REQ-010 d_addr_i, d_wdata_i  input  32 each  SHALL be the data address and store data.
REQ-011 d_gnt_o, d_rvalid_o  output  1 each; d_rdata_o  output  32  SHALL be the data-side grant, response valid and load data.
REQ-012 m_req_o, m_we_o  output  1 each; m_addr_o, m_wdata_o  output  32 each  SHALL be the shared memory request port.
REQ-013 m_gnt_i, m_rvalid_i  input  1 each; m_rdata_i  input  32  SHALL be the memory accept, response valid (reads and writes) and read data.

Function
REQ-014 FSM states SHALL be IDLE, REQ, RESP; one transaction outstanding at most.
REQ-015 In IDLE with any request pending, arbiter SHALL pick owner, pulse owner's gnt combinationally that cycle, latch owner/we/addr/wdata, go to REQ next cycle.
REQ-016 Selection SHALL be D over I, except I wins when starve counter == STARVE_MAX.
REQ-017 Starve counter (4 bit) SHALL increment on each D grant with i_req_i high, saturate at STARVE_MAX, clear on each I grant.
REQ-018 Non-owner gnt SHALL be 0; gnt SHALL never be 1 outside IDLE.
REQ-019 In REQ, m_req_o SHALL be 1 with latched m_we_o/m_addr_o/m_wdata_o stable until m_gnt_i=1; then go to RESP.
REQ-020 In REQ with m_gnt_i=1 and m_rvalid_i=1 same cycle, response SHALL be delivered that cycle and FSM SHALL go directly to IDLE.
REQ-021 In RESP, m_req_o SHALL be 0; on m_rvalid_i=1, owner rvalid SHALL assert same cycle, FSM to IDLE next cycle.
REQ-022 i_rdata_o/d_rdata_o SHALL pass m_rdata_i combinationally; value only meaningful when the matching rvalid is 1.
REQ-023 m_we_o SHALL be 0 for I-owned transactions.
REQ-024 m_rvalid_i in IDLE SHALL be ignored (no rvalid to either requester).
REQ-025 Request-to-m_req_o latency SHALL be exactly 1 cycle; IDLE cycle between consecutive transactions is mandatory.
REQ-026 Request inputs dropped before grant SHALL be treated as withdrawn; inputs changing after grant SHALL not affect the latched transaction.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, starve counter 0, latched fields 0, all gnt/rvalid/m_req_o/m_we_o 0, m_addr_o/m_wdata_o 0.
REQ-028 Reset mid-transaction SHALL abandon it; a late m_rvalid_i after release SHALL be ignored per REQ-024.

Verification
REQ-029 I-only read: i_req_i=1, i_addr_i=0x100, m_gnt_i=1 at cycle 2, m_rvalid_i=1 m_rdata_i=0x00500093 at cycle 4 -> i_gnt_o cycle 0, m_req_o cycles 1-2 addr 0x100, i_rvalid_o cycle 4 data 0x00500093, IDLE cycle 5.
REQ-030 Simultaneous: i_req_i=d_req_i=1, d_we_i=1, d_addr_i=0x2000, d_wdata_i=0xDEADBEEF -> d_gnt_o first, m_we_o=1 addr 0x2000 data 0xDEADBEEF; I granted next IDLE.
REQ-031 Starvation: D and I requesting continuously, STARVE_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-032 Zero-latency memory: m_gnt_i and m_rvalid_i tied 1 -> each transaction 2 cycles (IDLE, REQ); rvalid in REQ cycle.
REQ-033 Backpressure: m_gnt_i=0 for 5 cycles -> m_req_o held 5+ cycles, m_addr_o constant while d_addr_i changes.
REQ-034 Reset in RESP: rst_n low 1 cycle, then m_rvalid_i=1 -> all outputs 0, no rvalid, starve counter 0.
